// File: rtl/sram_phy_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_phy_ctrl
// Brief    : Physical-side controller for a 256Kx16 asynchronous SRAM.
//            Turns one sram_req/sram_ready transaction into CE/WE/OE and
//            byte-lane strobe sequences and returns read data as a one-cycle
//            valid pulse. Data-bus tristate is resolved one level up.
// Revision : 1.0 - initial release
// ============================================================================
module sram_phy_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        a_clk,
    input  logic        a_rst,
    input  logic        sram_req,
    output logic        sram_ready,
    input  logic        sram_rd,
    input  logic [17:0] sram_addr,
    input  logic [1:0]  sram_be,
    input  logic [15:0] sram_wr_data,
    output logic        sram_rd_data_vld,
    output logic [15:0] sram_rd_data,
    output logic [17:0] pin_a,
    output logic [15:0] pin_dq_out,
    input  logic [15:0] pin_dq_in,
    output logic        pin_dq_oe,
    output logic        pin_cs_n,
    output logic        pin_we_n,
    output logic        pin_oe_n,
    output logic        pin_ub_n,
    output logic        pin_lb_n
);

    localparam int             CW         = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0]  C_CNT_LOAD = CW'(WAIT_CYCLES - 1);

    // A zero-length access would never assert the strobes at all.
    if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
        $error("sram_phy_ctrl: WAIT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ACC   = 3'd1,
        S_RD_DONE  = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5
    } state_t;

    state_t         r_state,   w_state;
    logic [CW-1:0]  r_cnt,     w_cnt;
    logic           r_ready,   w_ready;
    logic           r_vld,     w_vld;
    logic [15:0]    r_rd_data, w_rd_data;
    logic [17:0]    r_a,       w_a;
    logic [15:0]    r_dq_out,  w_dq_out;
    logic           r_dq_oe,   w_dq_oe;
    logic           r_cs_n,    w_cs_n;
    logic           r_we_n,    w_we_n;
    logic           r_oe_n,    w_oe_n;
    logic           r_ub_n,    w_ub_n;
    logic           r_lb_n,    w_lb_n;

    // Next-state and next-output decode; every output holds unless changed.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_ready   = r_ready;
        w_vld     = r_vld;
        w_rd_data = r_rd_data;
        w_a       = r_a;
        w_dq_out  = r_dq_out;
        w_dq_oe   = r_dq_oe;
        w_cs_n    = r_cs_n;
        w_we_n    = r_we_n;
        w_oe_n    = r_oe_n;
        w_ub_n    = r_ub_n;
        w_lb_n    = r_lb_n;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b0;
                w_vld   = 1'b0;
                if (sram_req) begin
                    w_a    = sram_addr;
                    w_cs_n = 1'b0;
                    if (sram_rd) begin
                        // Reads always fetch the full word; lane masking is the bridge's job.
                        w_oe_n  = 1'b0;
                        w_ub_n  = 1'b0;
                        w_lb_n  = 1'b0;
                        w_cnt   = C_CNT_LOAD;
                        w_state = S_RD_ACC;
                    end else begin
                        w_dq_out = sram_wr_data;
                        w_ub_n   = ~sram_be[1];
                        w_lb_n   = ~sram_be[0];
                        w_we_n   = 1'b1;
                        w_dq_oe  = 1'b1;
                        w_state  = S_WR_SETUP;
                    end
                end
            end
            S_RD_ACC: begin
                if (r_cnt == '0) begin
                    w_rd_data = pin_dq_in;
                    w_vld     = 1'b1;
                    w_ready   = 1'b1;
                    w_cs_n    = 1'b1;
                    w_oe_n    = 1'b1;
                    w_ub_n    = 1'b1;
                    w_lb_n    = 1'b1;
                    w_state   = S_RD_DONE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_RD_DONE: begin
                // Upstream still holds req here; it must not be re-sampled.
                w_ready = 1'b0;
                w_vld   = 1'b0;
                w_state = S_IDLE;
            end
            S_WR_SETUP: begin
                w_we_n  = 1'b0;
                w_cnt   = C_CNT_LOAD;
                w_state = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (r_cnt == '0) begin
                    w_we_n  = 1'b1;
                    w_ready = 1'b1;
                    w_state = S_WR_HOLD;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_WR_HOLD: begin
                // Data stays driven one more cycle after WE rises for hold time.
                w_cs_n  = 1'b1;
                w_ub_n  = 1'b1;
                w_lb_n  = 1'b1;
                w_dq_oe = 1'b0;
                w_ready = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_ready = 1'b0;
                w_vld   = 1'b0;
                w_dq_oe = 1'b0;
                w_cs_n  = 1'b1;
                w_we_n  = 1'b1;
                w_oe_n  = 1'b1;
                w_ub_n  = 1'b1;
                w_lb_n  = 1'b1;
                w_state = S_IDLE;
            end
        endcase
    end

    // State, counter and all outputs registered; reset parks the chip deselected.
    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_vld     <= 1'b0;
            r_rd_data <= '0;
            r_a       <= '0;
            r_dq_out  <= '0;
            r_dq_oe   <= 1'b0;
            r_cs_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_ub_n    <= 1'b1;
            r_lb_n    <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_ready   <= w_ready;
            r_vld     <= w_vld;
            r_rd_data <= w_rd_data;
            r_a       <= w_a;
            r_dq_out  <= w_dq_out;
            r_dq_oe   <= w_dq_oe;
            r_cs_n    <= w_cs_n;
            r_we_n    <= w_we_n;
            r_oe_n    <= w_oe_n;
            r_ub_n    <= w_ub_n;
            r_lb_n    <= w_lb_n;
        end
    end

    assign sram_ready       = r_ready;
    assign sram_rd_data_vld = r_vld;
    assign sram_rd_data     = r_rd_data;
    assign pin_a            = r_a;
    assign pin_dq_out       = r_dq_out;
    assign pin_dq_oe        = r_dq_oe;
    assign pin_cs_n         = r_cs_n;
    assign pin_we_n         = r_we_n;
    assign pin_oe_n         = r_oe_n;
    assign pin_ub_n         = r_ub_n;
    assign pin_lb_n         = r_lb_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_phy_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_phy_ctrl
// Brief    : Scoreboard bench for sram_phy_ctrl with a behavioural SRAM model,
//            plus latency checks on WAIT_CYCLES=1 and WAIT_CYCLES=5 copies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_phy_ctrl;

    logic        a_clk;
    logic        a_rst;
    logic        sram_req;
    logic        sram_ready;
    logic        sram_rd;
    logic [17:0] sram_addr;
    logic [1:0]  sram_be;
    logic [15:0] sram_wr_data;
    logic        sram_rd_data_vld;
    logic [15:0] sram_rd_data;
    logic [17:0] pin_a;
    logic [15:0] pin_dq_out;
    logic [15:0] pin_dq_in;
    logic        pin_dq_oe;
    logic        pin_cs_n;
    logic        pin_we_n;
    logic        pin_oe_n;
    logic        pin_ub_n;
    logic        pin_lb_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rd;
        logic [15:0] data;
        logic [17:0] addr;
        logic [1:0]  lanes_n;
        int          we_low;
        int          oe_low;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    logic [15:0] mem [256];

    sram_phy_ctrl #(.WAIT_CYCLES(2)) u_dut (
        .a_clk(a_clk), .a_rst(a_rst),
        .sram_req(sram_req), .sram_ready(sram_ready), .sram_rd(sram_rd),
        .sram_addr(sram_addr), .sram_be(sram_be), .sram_wr_data(sram_wr_data),
        .sram_rd_data_vld(sram_rd_data_vld), .sram_rd_data(sram_rd_data),
        .pin_a(pin_a), .pin_dq_out(pin_dq_out), .pin_dq_in(pin_dq_in),
        .pin_dq_oe(pin_dq_oe), .pin_cs_n(pin_cs_n), .pin_we_n(pin_we_n),
        .pin_oe_n(pin_oe_n), .pin_ub_n(pin_ub_n), .pin_lb_n(pin_lb_n)
    );

    // Extra instances for latency at the WAIT_CYCLES extremes
    logic [1:0]  x_req, x_ready, x_vld, x_dq_oe, x_cs_n, x_we_n, x_oe_n, x_ub_n, x_lb_n;
    logic        x_rd;
    logic [15:0] x_rd_data [2];
    logic [17:0] x_pin_a   [2];
    logic [15:0] x_dq_out  [2];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        sram_phy_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : 5)) u_x (
            .a_clk(a_clk), .a_rst(a_rst),
            .sram_req(x_req[g]), .sram_ready(x_ready[g]), .sram_rd(x_rd),
            .sram_addr(18'h00777), .sram_be(2'b11), .sram_wr_data(16'h5A5A),
            .sram_rd_data_vld(x_vld[g]), .sram_rd_data(x_rd_data[g]),
            .pin_a(x_pin_a[g]), .pin_dq_out(x_dq_out[g]), .pin_dq_in(16'hC0DE),
            .pin_dq_oe(x_dq_oe[g]), .pin_cs_n(x_cs_n[g]), .pin_we_n(x_we_n[g]),
            .pin_oe_n(x_oe_n[g]), .pin_ub_n(x_ub_n[g]), .pin_lb_n(x_lb_n[g])
        );
    end

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM chip model: combinational read, write on clock edges while WE is low
    assign pin_dq_in = (!pin_cs_n && !pin_oe_n) ? mem[pin_a[7:0]] : 16'hDEAD;

    always @(posedge a_clk) begin
        if (!a_rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h45] <= 16'hBEEF;
            mem[8'h10] <= 16'h1111;
            mem[8'h20] <= 16'h2222;
        end else if (!pin_cs_n && !pin_we_n) begin
            if (!pin_ub_n) mem[pin_a[7:0]][15:8] <= pin_dq_out[15:8];
            if (!pin_lb_n) mem[pin_a[7:0]][7:0]  <= pin_dq_out[7:0];
        end
    end

    // Monitor: per-transaction strobe counters, invariants, scoreboard pop on ready
    int mon_we = 0, mon_oe = 0, mon_cs = 0;
    always @(posedge a_clk) begin
        exp_t e;
        #1;
        if (!a_rst) begin
            mon_we = 0; mon_oe = 0; mon_cs = 0;
        end else begin
            check("oe_dq_excl", {31'd0, !(!pin_oe_n && pin_dq_oe)}, 32'd1);
            check("we_gated", {31'd0, pin_we_n || (pin_dq_oe && !pin_cs_n)}, 32'd1);
            if (sram_rd_data_vld && !sram_ready) check("vld_without_ready", 32'd1, 32'd0);
            if (sram_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("vld", {31'd0, sram_rd_data_vld}, {31'd0, e.rd});
                    if (e.rd) check("rd_data", {16'd0, sram_rd_data}, {16'd0, e.data});
                    check("pin_a", {14'd0, pin_a}, {14'd0, e.addr});
                    check("lanes_n", {30'd0, pin_ub_n, pin_lb_n}, {30'd0, e.lanes_n});
                    check("we_low_cycles", mon_we, e.we_low);
                    check("oe_low_cycles", mon_oe, e.oe_low);
                    check("latency", mon_cs, e.lat);
                end
                mon_we = 0; mon_oe = 0; mon_cs = 0;
            end else begin
                if (!pin_we_n) mon_we++;
                if (!pin_oe_n) mon_oe++;
                if (!pin_cs_n) mon_cs++;
            end
        end
    end

    always @(posedge a_clk) begin
        #1;
        if (a_rst) begin
            for (int g = 0; g < 2; g++)
                check("x_oe_dq_excl", {31'd0, !(!x_oe_n[g] && x_dq_oe[g])}, 32'd1);
        end
    end

    // Issue one bridge request (caller is at a negedge); holds req through the
    // cycle after ready, then drops it unless another request follows.
    task automatic issue(input bit rd, input logic [17:0] addr, input logic [1:0] be,
                         input logic [15:0] wd, input logic [15:0] exp_data, input bit last);
        exp_t e;
        bit   seen;
        e.rd      = rd;
        e.data    = exp_data;
        e.addr    = addr;
        e.lanes_n = rd ? 2'b11 : ~be;
        e.we_low  = rd ? 0 : 2;
        e.oe_low  = rd ? 2 : 0;
        e.lat     = rd ? 2 : 3;
        sb_q.push_back(e);
        sram_req     = 1'b1;
        sram_rd      = rd;
        sram_addr    = addr;
        sram_be      = be;
        sram_wr_data = wd;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge a_clk); #1;
            if (sram_ready) seen = 1'b1;
            // Perturb inputs after acceptance; the DUT must ignore them.
            sram_addr    = ~addr;
            sram_be      = ~be;
            sram_wr_data = ~wd;
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        @(posedge a_clk);
        @(negedge a_clk);
        if (last) sram_req = 1'b0;
    endtask

    task automatic lat_test(input int idx, input bit rd, input int exp_lat);
        int lat;
        @(negedge a_clk);
        x_rd       = rd;
        x_req[idx] = 1'b1;
        lat        = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(posedge a_clk); #1;
            if (x_ready[idx]) begin
                lat = k;
                check("x_vld", {31'd0, x_vld[idx]}, {31'd0, rd});
                if (rd) check("x_rd_data", {16'd0, x_rd_data[idx]}, 32'h0000C0DE);
            end
        end
        check("x_latency", lat, exp_lat);
        @(posedge a_clk);
        @(negedge a_clk);
        x_req[idx] = 1'b0;
        repeat (2) @(negedge a_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst        = 1'b0;
        sram_req     = 1'b1;
        sram_rd      = 1'b1;
        sram_addr    = 18'h12345;
        sram_be      = 2'b00;
        sram_wr_data = 16'h0000;
        x_req        = 2'b00;
        x_rd         = 1'b0;

        // Reset held with a pending request: chip parked, no ready
        for (int i = 0; i < 3; i++) begin
            @(posedge a_clk); #1;
            check("rst_strobes", {27'd0, pin_cs_n, pin_we_n, pin_oe_n, pin_ub_n, pin_lb_n}, 32'h1F);
            check("rst_dq_oe", {31'd0, pin_dq_oe}, 32'd0);
            check("rst_ready", {30'd0, sram_ready, sram_rd_data_vld}, 32'd0);
            check("rst_pin_a", {14'd0, pin_a}, 32'd0);
        end
        @(negedge a_clk);
        a_rst = 1'b1;

        // Read accepted on the first edge after release
        issue(1'b1, 18'h12345, 2'b00, 16'h0000, 16'hBEEF, 1'b1);
        repeat (2) @(negedge a_clk);

        // Write upper byte only, then read back, then masked writes
        issue(1'b0, 18'h00010, 2'b10, 16'hA55A, 16'h0000, 1'b0);
        check("rd_data_hold", {16'd0, sram_rd_data}, 32'h0000BEEF);
        check("mem_upper_only", {16'd0, mem[8'h10]}, 32'h0000A511);
        issue(1'b1, 18'h00010, 2'b00, 16'h0000, 16'hA511, 1'b0);
        issue(1'b0, 18'h00020, 2'b00, 16'hFFFF, 16'h0000, 1'b0);
        check("mem_be00_untouched", {16'd0, mem[8'h20]}, 32'h00002222);
        issue(1'b0, 18'h00020, 2'b01, 16'h1234, 16'h0000, 1'b0);
        issue(1'b1, 18'h00020, 2'b00, 16'h0000, 16'h2234, 1'b1);
        repeat (3) @(negedge a_clk);

        // Asynchronous reset during the write pulse, between clock edges
        sram_req     = 1'b1;
        sram_rd      = 1'b0;
        sram_addr    = 18'h00030;
        sram_be      = 2'b11;
        sram_wr_data = 16'h5555;
        begin
            bit lo;
            lo = 1'b0;
            for (int k = 0; k < 10 && !lo; k++) begin
                @(posedge a_clk); #1;
                if (!pin_we_n) lo = 1'b1;
            end
            check("we_pulse_seen", {31'd0, lo}, 32'd1);
        end
        #2;
        a_rst = 1'b0;
        #1;
        check("arst_we_n", {31'd0, pin_we_n}, 32'd1);
        check("arst_cs_n", {31'd0, pin_cs_n}, 32'd1);
        check("arst_dq_oe", {31'd0, pin_dq_oe}, 32'd0);
        check("arst_ready", {31'd0, sram_ready}, 32'd0);
        sram_req = 1'b0;
        repeat (2) @(negedge a_clk);
        a_rst = 1'b1;
        repeat (3) @(negedge a_clk);
        issue(1'b1, 18'h12345, 2'b00, 16'h0000, 16'hBEEF, 1'b1);
        repeat (2) @(negedge a_clk);

        // Latency at WAIT_CYCLES=1 and 5
        lat_test(0, 1'b1, 1);
        lat_test(0, 1'b0, 2);
        lat_test(1, 1'b1, 5);
        lat_test(1, 1'b0, 6);

        repeat (3) @(negedge a_clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_phy_ctrl.md
Name: sram_phy_ctrl

Overview:
- Physical-side controller for the Blackice-II 256Kx16 asynchronous SRAM; sits directly downstream of the AXI-to-SRAM bridge and consumes its sram_* request interface.
- Converts one request/ready transaction at a time into chip-enable, write-enable, output-enable and byte-lane strobe sequences, then returns read data as a one-cycle valid pulse.
- Tristate resolution of the data bus is done in the top level; this block exposes separate dq out, dq in and dq output-enable signals.

Parameters:
- WAIT_CYCLES, 2, read-access and write-pulse length in clocks; must be >=1 (elaboration error otherwise).

Ports:
- a_clk  in  1  clock.
- a_rst  in  1  reset; asynchronous, active-low.
- sram_req  in  1  request; held high by upstream until the cycle after sram_ready.
- sram_ready  out  1  one-cycle completion pulse.
- sram_rd  in  1  1=read, 0=write.
- sram_addr  in  18  word address.
- sram_be  in  2  byte enables; bit1=upper byte, bit0=lower byte; write only.
- sram_wr_data  in  16  write data.
- sram_rd_data_vld  out  1  one-cycle read-data valid pulse.
- sram_rd_data  out  16  read data.
- pin_a  out  18  chip address.
- pin_dq_out  out  16  data driven to chip.
- pin_dq_in  in  16  data from chip.
- pin_dq_oe  out  1  1=FPGA drives dq.
- pin_cs_n  out  1  chip select.
- pin_we_n  out  1  write enable.
- pin_oe_n  out  1  output enable.
- pin_ub_n  out  1  upper byte enable.
- pin_lb_n  out  1  lower byte enable.

Behaviour:
- Reset (a_rst=0, async, mid-operation included):
  - state=IDLE; sram_ready=0; sram_rd_data_vld=0; sram_rd_data=0; pin_a=0; pin_dq_out=0; pin_dq_oe=0.
  - pin_cs_n, pin_we_n, pin_oe_n, pin_ub_n, pin_lb_n all =1.
  - Any in-flight transaction is dropped with no ready pulse.
- All outputs are registered. The counter is $clog2(WAIT_CYCLES+1) bits wide.
- States: IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - All strobes inactive; pin_dq_oe=0; pin_a holds its last value.
  - sram_req is sampled at each edge.
  - sram_req & sram_rd -> RD_ACC: latch pin_a=sram_addr; cs_n=0; oe_n=0; ub_n=lb_n=0 (sram_be ignored on reads); cnt=WAIT_CYCLES-1.
  - sram_req & !sram_rd -> WR_SETUP: latch pin_a, pin_dq_out=sram_wr_data, ub_n=~be[1], lb_n=~be[0]; cs_n=0; we_n=1; pin_dq_oe=1.
- RD_ACC:
  - Decrement cnt each cycle.
  - When cnt==0 -> RD_DONE: sram_rd_data<=pin_dq_in; sram_rd_data_vld<=1; sram_ready<=1; cs_n, oe_n, ub_n, lb_n <=1.
- RD_DONE:
  - Lasts exactly one cycle; next edge -> IDLE with ready and vld cleared.
  - sram_req is not sampled in this state, even though upstream still holds it high.
- WR_SETUP:
  - One cycle (address/data setup).
  - -> WR_PULSE: we_n=0; cnt=WAIT_CYCLES-1.
- WR_PULSE:
  - When cnt==0 -> WR_HOLD: we_n=1; sram_ready<=1.
  - Address, data, cs_n and byte lanes stay driven.
- WR_HOLD:
  - One cycle (data hold); sram_req is not sampled.
  - Next edge -> IDLE: cs_n=1, ub_n=lb_n=1, pin_dq_oe=0, sram_ready=0.
- Latency, measured from the edge that samples sram_req=1 in IDLE:
  - Read: sram_ready and vld high after WAIT_CYCLES edges.
  - Write: sram_ready high after WAIT_CYCLES+1 edges.
- pin_dq_oe and pin_oe_n are never both active; pin_we_n=0 only while pin_dq_oe=1 and pin_cs_n=0.
- A write with sram_be=00 still runs the full cycle with both lanes masked and still pulses sram_ready.
- sram_rd_data holds its value between reads. sram_rd_data_vld is never asserted for writes.
- Changes on sram_addr, sram_wr_data or sram_be after acceptance have no effect until IDLE.

Test Plan:
- Reset: hold a_rst=0 with sram_req=1 -> all strobes 1, pin_dq_oe=0, no ready pulse; release reset -> request accepted on the next edge.
- Read, WAIT_CYCLES=2: addr=0x12345, chip model returns 0xBEEF -> pin_a=0x12345, cs_n=oe_n=0 for 2 cycles; vld=ready=1 for exactly one cycle after edge 2 with data 0xBEEF; we_n stays 1.
- Write, WAIT_CYCLES=2: addr=0x00010, data=0xA55A, be=10 -> setup cycle, then we_n=0 for 2 cycles, then a hold cycle with ready=1; ub_n=0, lb_n=1 throughout; model stores only the upper byte 0xA5.
- Back-to-back with the bridge: write then read of the same address -> read returns the written data; exactly one ready per request; no request re-accepted during RD_DONE or WR_HOLD.
- Async reset asserted mid-WR_PULSE -> we_n, cs_n return to 1 and pin_dq_oe to 0 without a clock edge; no ready pulse; IDLE after release.
- WAIT_CYCLES=1 and 5 -> read latency 1 and 5 edges, write latency 2 and 6 edges; pin_oe_n and pin_dq_oe never simultaneously active.
